// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle IEEE-754 single-precision add/subtract controller.
// One shared shift/add datapath steps through unpack, align, add, normalize
// and round. Alignment and normalization move one bit per cycle.
module fp_addsub_sequencer #(
  parameter int MANT_W    = 28,
  parameter int MAX_ALIGN = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_overflow,
  output logic        flag_inexact
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    T_ZERO, T_DENORM, T_NORMAL, T_INF, T_NAN
  } fp_type_t;

  function automatic fp_type_t classify(input logic [31:0] x);
    fp_type_t t;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) t = T_NAN;
      else                  t = T_INF;
    end else if (x[30:23] == 8'h00) begin
      if (x[22:0] != 23'd0) t = T_DENORM;
      else                  t = T_ZERO;
    end else begin
      t = T_NORMAL;
    end
    return t;
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         opa_q, opa_d, opb_q, opb_d;
  logic                sub_q, sub_d;
  logic [MANT_W-1:0]   mant_l_q, mant_l_d, mant_s_q, mant_s_d;
  logic [9:0]          exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                eff_sub_q, eff_sub_d;
  logic                zero_sign_q, zero_sign_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic                invalid_q, invalid_d;
  logic                overflow_q, overflow_d;
  logic                inexact_q, inexact_d;
  logic                out_valid_q, out_valid_d;

  fp_type_t            type_a, type_b;
  logic                sign_a, sign_b;
  logic [7:0]          exp_a_eff, exp_b_eff;
  logic [MANT_W-1:0]   mant_a, mant_b;
  logic                a_larger;
  logic [7:0]          exp_diff;
  logic [4:0]          align_cnt;
  logic                round_up;
  logic                grs_any;
  logic [24:0]         rounded;
  logic [9:0]          exp_rnd;

  // Unpack view of the captured operands; B's sign is flipped for subtraction
  assign type_a    = classify(opa_q);
  assign type_b    = classify(opb_q);
  assign sign_a    = opa_q[31];
  assign sign_b    = opb_q[31] ^ sub_q;
  assign exp_a_eff = (opa_q[30:23] == 8'h00) ? 8'd1 : opa_q[30:23];
  assign exp_b_eff = (opb_q[30:23] == 8'h00) ? 8'd1 : opb_q[30:23];
  assign mant_a    = {1'b0, opa_q[30:23] != 8'h00, opa_q[22:0], 3'b000};
  assign mant_b    = {1'b0, opb_q[30:23] != 8'h00, opb_q[22:0], 3'b000};
  assign a_larger  = {exp_a_eff, mant_a} >= {exp_b_eff, mant_b};
  assign exp_diff  = a_larger ? (exp_a_eff - exp_b_eff) : (exp_b_eff - exp_a_eff);
  assign align_cnt = (exp_diff > 8'(MAX_ALIGN)) ? 5'(MAX_ALIGN) : exp_diff[4:0];

  // Round-to-nearest-even on guard/round/sticky with bit 3 as the LSB
  assign grs_any  = |mant_l_q[2:0];
  assign round_up = mant_l_q[2] & (mant_l_q[1] | mant_l_q[0] | mant_l_q[3]);
  assign rounded  = {1'b0, mant_l_q[26:3]} + {24'd0, round_up};
  assign exp_rnd  = exp_q + {9'd0, rounded[24]};

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign flag_invalid  = invalid_q;
  assign flag_overflow = overflow_q;
  assign flag_inexact  = inexact_q;

  // Next-state and datapath step for the current phase of the operation
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sub_d       = sub_q;
    mant_l_d    = mant_l_q;
    mant_s_d    = mant_s_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    zero_sign_d = zero_sign_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    invalid_d   = invalid_q;
    overflow_d  = overflow_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d      = op_a;
          opb_d      = op_b;
          sub_d      = op_sub;
          invalid_d  = 1'b0;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (type_a == T_NAN || type_b == T_NAN ||
            (type_a == T_INF && type_b == T_INF && sign_a != sign_b)) begin
          result_d  = 32'h7FC00000;
          invalid_d = 1'b1;
          state_d   = S_DONE;
        end else if (type_a == T_INF) begin
          result_d = {sign_a, 8'hFF, 23'd0};
          state_d  = S_DONE;
        end else if (type_b == T_INF) begin
          result_d = {sign_b, 8'hFF, 23'd0};
          state_d  = S_DONE;
        end else begin
          mant_l_d    = a_larger ? mant_a : mant_b;
          mant_s_d    = a_larger ? mant_b : mant_a;
          exp_d       = {2'b00, a_larger ? exp_a_eff : exp_b_eff};
          sign_d      = a_larger ? sign_a : sign_b;
          eff_sub_d   = sign_a ^ sign_b;
          zero_sign_d = sign_a & sign_b;
          cnt_d       = align_cnt;
          state_d     = (align_cnt == 5'd0) ? S_ADD : S_ALIGN;
        end
      end
      S_ALIGN: begin
        mant_s_d = {1'b0, mant_s_q[MANT_W-1:2], mant_s_q[1] | mant_s_q[0]};
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_ADD;
      end
      S_ADD: begin
        mant_l_d = eff_sub_q ? (mant_l_q - mant_s_q) : (mant_l_q + mant_s_q);
        state_d  = S_NORM;
      end
      S_NORM: begin
        if (mant_l_q[27]) begin
          mant_l_d = {1'b0, mant_l_q[27:2], mant_l_q[1] | mant_l_q[0]};
          exp_d    = exp_q + 10'd1;
          state_d  = S_ROUND;
        end else if (!mant_l_q[26] && mant_l_q != '0 && exp_q > 10'd1) begin
          mant_l_d = {mant_l_q[26:0], 1'b0};
          exp_d    = exp_q - 10'd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (mant_l_q == '0) begin
          result_d = {zero_sign_q, 31'd0};
        end else if (exp_rnd >= 10'd255) begin
          result_d   = {sign_q, 8'hFF, 23'd0};
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          result_d[31]    = sign_q;
          result_d[30:23] = (rounded[24] | rounded[23]) ? exp_rnd[7:0] : 8'h00;
          result_d[22:0]  = rounded[24] ? rounded[23:1] : rounded[22:0];
          inexact_d       = grs_any;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sub_q       <= 1'b0;
      mant_l_q    <= '0;
      mant_s_q    <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      zero_sign_q <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sub_q       <= sub_d;
      mant_l_q    <= mant_l_d;
      mant_s_q    <= mant_s_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      zero_sign_q <= zero_sign_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      overflow_q  <= overflow_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed testbench for fp_addsub_sequencer with hand-computed results,
// flags and latencies.
module tb_fp_addsub_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid;
  logic        flag_overflow;
  logic        flag_inexact;

  int checkCount;
  int errorCount;

  fp_addsub_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sub       (op_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_invalid (flag_invalid),
    .flag_overflow(flag_overflow),
    .flag_inexact (flag_inexact)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Run one operation: transfer, measure latency, hold the sink off for
  // 'hold' cycles, then accept the result
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic sub,
                               input logic [31:0] expRes, input logic [2:0] expFlags,
                               input int expLat, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    checkOutput({name, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'hDEADBEEF;
    op_b     = 32'h7FC12345;
    op_sub   = ~sub;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      checkOutput({name, " timeout"}, 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " result"}, result, expRes);
    checkOutput({name, " flags"}, {29'd0, flag_invalid, flag_overflow, flag_inexact},
                {29'd0, expFlags});
    checkOutput({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, " hold result"}, result, expRes);
      checkOutput({name, " hold valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({name, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " out_valid after"}, {31'd0, out_valid}, 32'd0);
    checkOutput({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Directed sequence of operations, reset checks and summary
  initial begin
    logic sawValid;
    checkCount = 0;
    errorCount = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset flags", {29'd0, flag_invalid, flag_overflow, flag_inexact}, 32'd0);

    applyStimulus("one+one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5, 0);
    applyStimulus("one-one",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 5, 0);
    applyStimulus("tiny add",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 32, 0);
    applyStimulus("inf-inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 2, 0);
    applyStimulus("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 5, 0);
    applyStimulus("1.5+0.25",  32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 3'b000, 7, 10);
    applyStimulus("1-0.75",    32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 8, 0);
    applyStimulus("nan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 2, 0);
    applyStimulus("-inf-1",    32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000, 2, 0);
    applyStimulus("inf--inf",  32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000, 2, 0);
    applyStimulus("-0+-0",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 5, 0);
    applyStimulus("denorm",    32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 5, 0);
    applyStimulus("tie even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 29, 0);
    applyStimulus("tie odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 29, 0);

    // Reset while the long alignment is in progress
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 32'h3F800000;
    op_b     = 32'h30800000;
    op_sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort no output", {31'd0, sawValid}, 32'd0);

    applyStimulus("after rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fp_addsub_sequencer.md
# fp_addsub_sequencer

Multi-cycle controller that sequences the single-precision add/subtract operand path: unpack, classify, align the smaller operand, add/subtract, normalize, round and pack. Alignment and normalization run one bit position per cycle. One shared shift/add datapath therefore serves the whole operation, trading latency for area. The block sits between an operand source and a result sink, with valid/ready handshakes on both sides, and processes one operation at a time.

## Interface
- MANT_W, 28, internal mantissa width: bit 27 carry, bit 26 hidden, bits 25:3 fraction, bit 2 guard, bit 1 round, bit 0 sticky.
- MAX_ALIGN, 27, alignment shift count cap; larger exponent differences saturate to this.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- op_a  in  32  IEEE-754 single operand A.
- op_b  in  32  IEEE-754 single operand B.
- op_sub  in  1  0 = A+B, 1 = A−B (sign of B inverted at unpack).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  sink accepts result.
- result  out  32  IEEE-754 single result.
- flag_invalid  out  1  inf−inf or NaN operand.
- flag_overflow  out  1  finite operands rounded to ±inf.
- flag_inexact  out  1  any of guard/round/sticky set before rounding, or overflow.

## Operation
- Handshake: a transfer occurs when in_valid&in_ready; result transfer when out_valid&out_ready. Operands are captured at the input transfer edge; later op_a/op_b changes are ignored.
- States: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
- Transitions:
  - UNPACK → DONE for special cases.
  - UNPACK → ADD when the exponent difference is 0 (ALIGN skipped).
  - DONE → IDLE on out_ready.
- UNPACK, classification per operand (3-bit type): zero, denormal, normal, inf, NaN.
  - Denormals use hidden bit 0 and effective exponent 1.
  - Larger-magnitude operand is selected by exponent, then mantissa. Its sign, and its exponent as working exponent, are kept.
  - The exponent difference saturates to d = min(diff, MAX_ALIGN).
- Special cases (direct to DONE):
  - Any NaN → 0x7FC00000, invalid=1.
  - inf − inf (effective) → 0x7FC00000, invalid=1.
  - Otherwise, any inf → that inf.
- ALIGN: shift the smaller mantissa right 1 bit per cycle for d cycles. Shifted-out bits are ORed into bit 0 (sticky).
- ADD: add mantissas if effective signs are equal, else subtract smaller from larger; the result is ≥ 0.
- NORM:
  - If bit 27 is set: right shift 1 with sticky OR, exponent +1, in one cycle.
  - Otherwise, while bit 26 is clear, mantissa ≠ 0 and exponent > 1: left shift 1 and exponent −1, one per cycle (k cycles). One final detect cycle follows.
  - Zero mantissa → result +0 (−0 only if both operands are −0 under effective add).
- ROUND: round-to-nearest-even on bits 2:0 with LSB bit 3.
  - A carry out of rounding renormalizes (exponent +1).
  - Exponent ≥ 255 → ±inf, overflow=1, inexact=1.
  - Exponent 1 with hidden bit 0 → denormal encoding (exponent field 0).
- Flags are valid with result and cleared at the next input transfer.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Reset in any state aborts the operation with no output.
- Finite-operand latency: out_valid rises 5 + d + k cycles after the input transfer edge. The carry right-shift costs no extra cycle.
- Special-case latency: 2 cycles.
- Back-to-back: the next input transfer is possible in the cycle after the result transfer; in_ready is 0 from the accept edge until IDLE is re-entered.
- out_valid low → result and flags are don't-care but stable. While out_valid=1 and out_ready=0, result and flags hold unchanged.
- in_valid asserted while not in IDLE has no effect.

## Test plan
- 0x3F800000 + 0x3F800000 → 0x40000000, flags 0, out_valid 5 cycles after accept.
- 0x3F800000 − 0x3F800000 (op_sub=1) → 0x00000000, flags 0, latency 5.
- 0x3F800000 + 0x30800000 (diff 30, d=27) → 0x3F800000, inexact=1, latency 32.
- Infinity and overflow cases:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1, latency 2.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles after out_valid: result stable, in_ready=0. Release, then a new op is accepted the next cycle.
  - Assert rst during ALIGN: the next cycle shows in_ready=1 and out_valid=0.
